// File: rtl/env_pkg.sv
// Shared envelope types and gain constants.
package env_pkg;

  localparam int GAIN_W     = 11;
  localparam int GAIN_UNITY = 1024;
  localparam int GAIN_FRAC  = 10;
  localparam int SAMPLE_W   = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } env_state_e;

  // Returns a - b, but never less than floor_v. Compared one bit wider so
  // floor_v + b cannot wrap.
  function automatic logic [GAIN_W-1:0] sub_floor(
    input logic [GAIN_W-1:0] a,
    input logic [GAIN_W-1:0] b,
    input logic [GAIN_W-1:0] floor_v
  );
    if ({1'b0, a} <= ({1'b0, floor_v} + {1'b0, b})) return floor_v;
    else                                            return a - b;
  endfunction

endpackage

// File: rtl/env_gain_gen.sv
// ADSR state machine and gain register.
// ENV_EXP_RELEASE_EN selects an exponential release (gain -= max(gain>>RELEASE_SHIFT,1))
// instead of the default linear RELEASE_STEP decrement.
module env_gain_gen
  import env_pkg::*;
#(
  parameter int ATTACK_STEP   = 64,
  parameter int DECAY_STEP    = 8,
  parameter int SUSTAIN_LEVEL = 768,
  parameter int RELEASE_STEP  = 16,
  parameter int RELEASE_SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              note_start,
  input  logic              note_release,
  input  logic              sample_in_valid,
  output logic [GAIN_W-1:0] gain,
  output logic              env_active,
  output logic              done
);

  localparam logic [GAIN_W:0]   ATK_W  = (GAIN_W+1)'(ATTACK_STEP);
  localparam logic [GAIN_W-1:0] DEC_W  = GAIN_W'(DECAY_STEP);
  localparam logic [GAIN_W-1:0] SUS_W  = GAIN_W'(SUSTAIN_LEVEL);
  localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(GAIN_UNITY);

  env_state_e        state;
  logic              rel_evt;
  logic              step;
  logic [GAIN_W:0]   atk_sum;
  logic [GAIN_W-1:0] atk_next;
  logic [GAIN_W-1:0] dec_next;
  logic [GAIN_W-1:0] rel_next;

  // A release only counts as an event when it actually changes state; an
  // ignored release (IDLE/RELEASE) does not suppress that cycle's step.
  assign rel_evt = note_release &&
                   (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN);
  assign step    = sample_in_valid && play_enable && !note_start && !rel_evt;

  assign atk_sum  = {1'b0, gain} + ATK_W;
  assign atk_next = (atk_sum >= (GAIN_W+1)'(GAIN_UNITY)) ? UNITY : atk_sum[GAIN_W-1:0];
  assign dec_next = sub_floor(gain, DEC_W, SUS_W);

`ifdef ENV_EXP_RELEASE_EN
  localparam int unused_release_step = RELEASE_STEP;
  logic [GAIN_W-1:0] rel_shr;
  logic [GAIN_W-1:0] rel_dec;
  assign rel_shr  = gain >> RELEASE_SHIFT;
  assign rel_dec  = (rel_shr == '0) ? GAIN_W'(1) : rel_shr;
  assign rel_next = sub_floor(gain, rel_dec, '0);
`else
  localparam int unused_release_shift = RELEASE_SHIFT;
  assign rel_next = sub_floor(gain, GAIN_W'(RELEASE_STEP), '0);
`endif

  assign env_active = (state != ST_IDLE);
  assign done       = step && (state == ST_RELEASE) && (rel_next == '0);

  // Envelope FSM: events first, then the per-sample gain step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      gain  <= '0;
    end else if (note_start) begin
      state <= ST_ATTACK;
    end else if (rel_evt) begin
      state <= ST_RELEASE;
    end else if (step) begin
      unique case (state)
        ST_ATTACK: begin
          gain <= atk_next;
          if (atk_next == UNITY) state <= ST_DECAY;
        end
        ST_DECAY: begin
          gain <= dec_next;
          if (dec_next == SUS_W) state <= ST_SUSTAIN;
        end
        ST_SUSTAIN: ;
        ST_RELEASE: begin
          gain <= rel_next;
          if (rel_next == '0) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          gain  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/note_envelope.sv
// ADSR envelope applied to the note player's sample stream, 1-cycle latency.
// Optional macro ENV_EXP_RELEASE_EN selects exponential release in env_gain_gen.
module note_envelope
  import env_pkg::*;
#(
  parameter int ATTACK_STEP   = 64,
  parameter int DECAY_STEP    = 8,
  parameter int SUSTAIN_LEVEL = 768,
  parameter int RELEASE_STEP  = 16,
  parameter int RELEASE_SHIFT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                note_start,
  input  logic                note_release,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_in_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic                env_active,
  output logic                note_done
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic [GAIN_W-1:0]        gain;
  logic                     done;
  logic signed [PROD_W-1:0] prod;
  logic [SAMPLE_W-1:0]      scaled;
  logic                     unused_prod;

  env_gain_gen #(
    .ATTACK_STEP  (ATTACK_STEP),
    .DECAY_STEP   (DECAY_STEP),
    .SUSTAIN_LEVEL(SUSTAIN_LEVEL),
    .RELEASE_STEP (RELEASE_STEP),
    .RELEASE_SHIFT(RELEASE_SHIFT)
  ) u_gen (
    .clk            (clk),
    .reset          (reset),
    .play_enable    (play_enable),
    .note_start     (note_start),
    .note_release   (note_release),
    .sample_in_valid(sample_in_valid),
    .gain           (gain),
    .env_active     (env_active),
    .done           (done)
  );

  // Signed 18 x 12 multiply with the pre-step gain; taking bits above the
  // fraction is an arithmetic shift (floor). gain <= unity so the top bits
  // are pure sign extension.
  assign prod        = $signed(sample_in) * $signed({1'b0, gain});
  assign scaled      = prod[GAIN_FRAC +: SAMPLE_W];
  assign unused_prod = ^{prod[PROD_W-1:GAIN_FRAC+SAMPLE_W], prod[GAIN_FRAC-1:0]};

  // Output stage: scaled sample, valid and done pulse aligned on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      note_done        <= 1'b0;
    end else begin
      sample_out_valid <= sample_in_valid;
      note_done        <= done;
      if (sample_in_valid) sample_out <= scaled;
    end
  end

endmodule
